matmul_mem_server: RTL and testbench
====================================

// Module: matmul_mem_server
// PURPOSE
//  - Word memory that serves the load/store transactions issued by the matrix-multiply top.
//  - Holds A/B operands (18 words) and the C results (9 words).
//  - Request/done handshake with a fixed programmable latency; downstream consumer of the
//    multiplier's address_out/data_out/start_memory_transaction.
// PARAMETERS
//  DEPTH      64     words of storage; power of two, >= 32
//  LATENCY    2      cycles from request accept to done pulse; >= 1
//  BASE_ADDR  0      byte address of word 0; 4-byte aligned
// PORTS
//  clk        in   1   single clock, all state on rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  mem_req    in   1   request; level, may stay high across back-to-back transactions
//  mem_we     in   1   1 = write, 0 = read; sampled at accept
//  mem_addr   in   32  byte address; sampled at accept
//  mem_wdata  in   32  write data; sampled at accept
//  mem_rdata  out  32  read data; valid while mem_done=1, held until next read completes
//  mem_done   out  1   one-cycle completion pulse
//  mem_err    out  1   error pulse coincident with mem_done (see CONFIGURATION)
//  busy       out  1   1 from accept until the cycle after mem_done
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    - State IDLE; mem_rdata=0, mem_done=0, mem_err=0, busy=0; latency counter=0.
//    - RAM contents not reset.
//  - Word index = (mem_addr - BASE_ADDR) >> 2, truncated to log2(DEPTH) bits.
//  - FSM: IDLE -> WAIT -> RESP -> IDLE.
//    - IDLE: on mem_req=1 at edge k, latch we/addr/wdata, busy=1, cnt=LATENCY-1, go WAIT.
//      If LATENCY=1, go RESP directly.
//    - WAIT: cnt decrements each cycle; at cnt=0 go RESP.
//    - RESP: mem_done=1 for exactly one cycle, at cycle k+LATENCY.
//      - Read: mem_rdata=RAM[index] registered into this cycle.
//      - Write: RAM[index]=latched wdata committed at the RESP edge; mem_rdata unchanged.
//      - Next state is always IDLE (one mandatory idle cycle); busy=0 in that IDLE cycle.
//  - Back-to-back: if mem_req is still high in the IDLE cycle after RESP, a new transaction
//    is accepted with the address/data present at that edge.
//    Max rate = one transaction per LATENCY+2 cycles.
//  - Inputs that change during WAIT/RESP are ignored.
//  - Read-after-write to the same word returns the new value (write commits before the
//    next accept).
//  - mem_req dropping during WAIT does not cancel; the transaction completes normally.
//  - Reset mid-transaction: transaction aborted, no RAM write, no done pulse.
//  - mem_addr[1:0] is ignored for indexing.
// CONFIGURATION
//  MEM_ERR_CHECK_EN defined:
//    - Error when mem_addr[1:0]!=0, mem_addr<BASE_ADDR, or index >= DEPTH (untruncated).
//    - Error response: mem_err=1 with mem_done; write suppressed; mem_rdata=32'hDEAD_BEEF.
//    - Timing is unchanged.
//  MEM_ERR_CHECK_EN undefined:
//    - No checking; out-of-range addresses wrap modulo DEPTH.
//    - mem_err tied to 0.
// TESTING
//  1. Reset: rst_n=0 mid-WAIT of a write to 0x08 -> done never pulses; later read 0x08
//     returns the pre-reset value; all outputs 0 during reset.
//  2. Latency: LATENCY=2; write 0x0000_1234 to 0x04 accepted at cycle 10 -> mem_done at 12;
//     read 0x04 accepted at 14 -> done at 16 with mem_rdata=0x0000_1234.
//  3. Held request: mem_req stuck high for 27 transactions (18 reads, 9 writes) ->
//     done pulses every 4 cycles (LATENCY=2); all data correct.
//  4. Wrap (macro off): DEPTH=64; write 0xA5 to byte 0x100 -> read at 0x000 returns 0xA5;
//     mem_err stays 0.
//  5. Error (macro on): read 0x102 -> mem_err=1, mem_rdata=0xDEAD_BEEF;
//     write 0x100 -> mem_err=1 and word 0 unchanged.
//  6. Request dropped after accept: mem_req 1 cycle only -> single done pulse, busy 1 for
//     LATENCY+1 cycles.

Source files
------------

// File: rtl/matmul_mem_server.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : matmul_mem_server
// Description : Word memory serving the matrix-multiply load/store traffic
//               through a req/done handshake with a fixed latency.
//               Optional address checking is enabled by `define MEM_ERR_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_mem_server #(
    parameter int          DEPTH     = 64,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_done,
    output logic        mem_err,
    output logic        busy
);

    localparam int               c_AW       = $clog2(DEPTH);
    localparam int               c_CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [c_CW-1:0]  c_CNT_INIT = c_CW'(LATENCY - 1);
    localparam logic [31:0]      c_ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [c_CW-1:0]   r_cnt;
    logic              r_we;
    logic              r_err;
    logic [c_AW-1:0]   r_idx;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic [31:0]       r_mem [DEPTH];

    logic [31:0]       w_off;
    logic [c_AW-1:0]   w_idx;
    logic              w_err;
    logic              w_accept;
    logic              w_resp_edge;
    logic              w_unused_bits;

    assign w_off = mem_addr - BASE_ADDR;
    assign w_idx = w_off[c_AW+1:2];

`ifdef MEM_ERR_CHECK_EN
    assign w_err = (mem_addr[1:0] != 2'b00) ||
                   (mem_addr < BASE_ADDR)   ||
                   ({2'b00, w_off[31:2]} >= 32'(DEPTH));
    assign w_unused_bits = ^w_off[1:0];
`else
    assign w_err = 1'b0;
    assign w_unused_bits = ^{w_off[31:c_AW+2], w_off[1:0]};
`endif

    assign w_accept    = (r_state == S_IDLE) && mem_req;
    // The WAIT phase always lasts LATENCY cycles, so done lands LATENCY edges after accept
    assign w_resp_edge = (r_state == S_WAIT) && (r_cnt == '0);

    always_comb begin
        w_next   = r_state;
        mem_done = 1'b0;
        busy     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mem_req) w_next = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (r_cnt == '0) w_next = S_RESP;
            end
            S_RESP: begin
                busy     = 1'b1;
                mem_done = 1'b1;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign mem_err   = mem_done & r_err;
    assign mem_rdata = r_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cnt   <= c_CNT_INIT;
                r_we    <= mem_we;
                r_err   <= w_err;
                r_idx   <= w_idx;
                r_wdata <= mem_wdata;
            end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_resp_edge && !r_we) begin
                r_rdata <= r_err ? c_ERR_DATA : r_mem[r_idx];
            end
        end
    end

    // Storage is deliberately left out of reset; only the commit strobe is reset-qualified
    always_ff @(posedge clk) begin
        if (w_resp_edge && r_we && !r_err) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matmul_mem_server.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_matmul_mem_server
// Description : Directed self-checking bench for matmul_mem_server
//               (DEPTH=64, LATENCY=2, BASE_ADDR=0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matmul_mem_server;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        mem_err;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    matmul_mem_server #(
        .DEPTH     (64),
        .LATENCY   (2),
        .BASE_ADDR (32'h0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .mem_err   (mem_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single transaction from an IDLE cycle; returns in the IDLE cycle after RESP
    task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er, output int lat);
        mem_req   = 1'b1;
        mem_we    = we;
        mem_addr  = a;
        mem_wdata = d;
        tick();
        mem_req = 1'b0;
        lat = 0;
        rd  = '0;
        er  = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (mem_done) begin
                lat = i;
                rd  = mem_rdata;
                er  = mem_err;
                break;
            end
        end
        tick();
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          prev_done;
    int          nb;
    int          nd;
    int          w;

    initial begin
        rst_n     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        repeat (3) tick();
        check("rst_rdata", mem_rdata, 32'h0);
        check("rst_done",  32'(mem_done), 32'h0);
        check("rst_err",   32'(mem_err), 32'h0);
        check("rst_busy",  32'(busy), 32'h0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Latency: write then read word 1
        txn(1'b1, 32'h04, 32'h0000_1234, rd, er, lat);
        check("lat_write", 32'(lat), 32'd2);
        check("lat_write_err", 32'(er), 32'h0);
        check("lat_rdata_hold", rd, 32'h0);
        txn(1'b0, 32'h04, 32'h0, rd, er, lat);
        check("lat_read", 32'(lat), 32'd2);
        check("lat_rdata", rd, 32'h0000_1234);

        // Held request: 9 writes then 18 reads, one done per 4 cycles
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = 32'h0;
        mem_wdata = 32'hC000_0000;
        prev_done = -1;
        for (int t = 0; t < 27; t++) begin
            w = 0;
            while (!mem_done && w < 20) begin
                tick();
                w++;
            end
            check("held_done", 32'(mem_done), 32'h1);
            if (prev_done >= 0) check("held_period", 32'(cyc - prev_done), 32'd4);
            prev_done = cyc;
            check("held_err", 32'(mem_err), 32'h0);
            if (t >= 9)
                check("held_rdata", mem_rdata, 32'hC000_0000 + 32'(((t - 9) % 9) * 32'h111));
            if (t < 26) begin
                mem_we    = (t + 1 < 9);
                mem_addr  = 32'(4 * ((t + 1 < 9) ? (t + 1) : ((t + 1 - 9) % 9)));
                mem_wdata = 32'hC000_0000 + 32'((t + 1) * 32'h111);
            end else begin
                mem_req = 1'b0;
            end
            tick();
        end
        tick();

`ifndef MEM_ERR_CHECK_EN
        // Address wrap modulo DEPTH
        txn(1'b1, 32'h100, 32'h0000_00A5, rd, er, lat);
        check("wrap_wr_err", 32'(er), 32'h0);
        txn(1'b0, 32'h000, 32'h0, rd, er, lat);
        check("wrap_rdata", rd, 32'h0000_00A5);
        check("wrap_rd_err", 32'(er), 32'h0);
`else
        // Address error responses
        txn(1'b1, 32'h000, 32'h0000_5A5A, rd, er, lat);
        txn(1'b0, 32'h102, 32'h0, rd, er, lat);
        check("err_misalign_flag", 32'(er), 32'h1);
        check("err_misalign_data", rd, 32'hDEAD_BEEF);
        check("err_misalign_lat", 32'(lat), 32'd2);
        txn(1'b1, 32'h100, 32'h1111_1111, rd, er, lat);
        check("err_range_flag", 32'(er), 32'h1);
        txn(1'b0, 32'h000, 32'h0, rd, er, lat);
        check("err_word0_kept", rd, 32'h0000_5A5A);
        check("err_word0_flag", 32'(er), 32'h0);
`endif

        // Request dropped after one cycle
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 32'h10;
        tick();
        mem_req = 1'b0;
        nb = 0;
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            nb += int'(busy);
            nd += int'(mem_done);
            tick();
        end
        check("drop_busy_cycles", 32'(nb), 32'd3);
        check("drop_done_pulses", 32'(nd), 32'd1);

        // Reset in the middle of a write
        txn(1'b1, 32'h08, 32'h1111_2222, rd, er, lat);
        txn(1'b0, 32'h08, 32'h0, rd, er, lat);
        check("pre_rst_rdata", rd, 32'h1111_2222);
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = 32'h08;
        mem_wdata = 32'h9999_0000;
        tick();
        mem_req = 1'b0;
        check("mid_busy", 32'(busy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rdata", mem_rdata, 32'h0);
        check("async_busy",  32'(busy), 32'h0);
        check("async_done",  32'(mem_done), 32'h0);
        check("async_err",   32'(mem_err), 32'h0);
        nd = 0;
        repeat (3) begin
            tick();
            nd += int'(mem_done);
        end
        rst_n = 1'b1;
        repeat (4) begin
            tick();
            nd += int'(mem_done);
        end
        check("rst_no_done", 32'(nd), 32'd0);
        txn(1'b0, 32'h08, 32'h0, rd, er, lat);
        check("rst_no_write", rd, 32'h1111_2222);
        check("rst_read_lat", 32'(lat), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
